// File: rtl/mem_access_sequencer_pkg.sv
// Shared encodings and defaults for the data-memory access sequencer.
package mem_access_sequencer_pkg;

  localparam int          DATA_W          = 16;
  localparam logic [31:0] SP_RESET_DEF    = 32'h000F_FFFF;
  localparam logic [31:0] STACK_LIMIT_DEF = 32'h000F_F000;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_PUSH   = 3'd3,
    OP_POP    = 3'd4,
    OP_PUSH32 = 3'd5,
    OP_POP32  = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op != OP_NONE) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/mem_access_sequencer.sv
// Sequences load/store/stack accesses onto one 16-bit data-memory port and owns SP.
// Optional stack overflow/underflow guard enabled by defining STACK_GUARD_EN.
//
// state | meaning
// IDLE  | ready for a new request
// ACC1  | first (or only) memory word access
// ACC2  | second word of a 32-bit push/pop
// DONE  | one-cycle response pulse
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] SP_RESET    = ADDR_W'(SP_RESET_DEF),
  parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(STACK_LIMIT_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] sp_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_cs
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e              state, state_d;
  op_e                 op_q;
  logic [ADDR_W-1:0]   addr_q, sp, sp_d;
  logic [31:0]         wdata_q;
  logic [DATA_W-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic                err_q, err_d;
  logic                guard_fail;

`ifdef STACK_GUARD_EN
  // Extended by one bit so the bounds compare cannot itself wrap.
  logic [ADDR_W:0] sp_ext, limit_ext, top_ext;
  assign sp_ext    = {1'b0, sp};
  assign limit_ext = {1'b0, STACK_LIMIT};
  assign top_ext   = {1'b0, SP_RESET};

  always_comb begin
    guard_fail = 1'b0;
    case (op_q)
      OP_PUSH:   guard_fail = sp_ext < limit_ext;
      OP_PUSH32: guard_fail = sp_ext < limit_ext + (ADDR_W+1)'(1);
      OP_POP:    guard_fail = sp_ext + (ADDR_W+1)'(1) > top_ext;
      OP_POP32:  guard_fail = sp_ext + (ADDR_W+1)'(2) > top_ext;
      default:   guard_fail = 1'b0;
    endcase
  end
`else
  assign guard_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sp      <= SP_RESET;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_d;
      sp    <= sp_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      err_q <= err_d;
      if (state == ST_IDLE && req_valid && is_valid_op(req_op)) begin
        op_q    <= op_e'(req_op);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d    = state;
    sp_d       = sp;
    lo_d       = lo_q;
    hi_d       = hi_q;
    err_d      = err_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && is_valid_op(req_op)) begin
          lo_d    = '0;
          hi_d    = '0;
          err_d   = 1'b0;
          state_d = ST_ACC1;
        end
      end
      ST_ACC1: begin
        state_d = ST_DONE;
        if (guard_fail) begin
          err_d = 1'b1;
        end else begin
          case (op_q)
            OP_LOAD:  begin mem_rd = 1'b1; mem_addr = addr_q; lo_d = mem_rdata; end
            OP_STORE: begin mem_wr = 1'b1; mem_addr = addr_q; mem_wdata = wdata_q[15:0]; end
            OP_PUSH: begin
              mem_wr = 1'b1; mem_addr = sp; mem_wdata = wdata_q[15:0]; sp_d = sp - ONE;
            end
            OP_POP: begin
              mem_rd = 1'b1; mem_addr = sp + ONE; lo_d = mem_rdata; sp_d = sp + ONE;
            end
            OP_PUSH32: begin
              mem_wr = 1'b1; mem_addr = sp; mem_wdata = wdata_q[31:16]; sp_d = sp - ONE;
              state_d = ST_ACC2;
            end
            OP_POP32: begin
              mem_rd = 1'b1; mem_addr = sp + ONE; lo_d = mem_rdata; sp_d = sp + ONE;
              state_d = ST_ACC2;
            end
            default: ;
          endcase
        end
      end
      ST_ACC2: begin
        state_d = ST_DONE;
        if (op_q == OP_PUSH32) begin
          mem_wr = 1'b1; mem_addr = sp; mem_wdata = wdata_q[15:0]; sp_d = sp - ONE;
        end else if (op_q == OP_POP32) begin
          mem_rd = 1'b1; mem_addr = sp + ONE; hi_d = mem_rdata; sp_d = sp + ONE;
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_data  = {hi_q, lo_q};
        resp_err   = err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_cs = mem_rd | mem_wr;
  assign busy   = (state != ST_IDLE);
  assign sp_out = sp;

endmodule
